// File: rtl/f_accum_reduce.sv
// Strided window reducer: MAX / MIN / SUM (wrap or saturate) / ARGMAX over
// S = strideMinusOne+1 samples, with a one-cycle valid pulse per completed window.
module f_accum_reduce #(
  parameter int DATA_W   = 32,
  parameter int STRIDE_W = 16,
  parameter int DELAY_W  = 7,
  parameter int SAT      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                running,
  input  logic [STRIDE_W-1:0] strideMinusOne,
  input  logic [1:0]          mode,
  input  logic [DELAY_W-1:0]  delay0,
  input  logic [DATA_W-1:0]   in0,
  output logic [DATA_W-1:0]   out0,
  output logic [STRIDE_W-1:0] outIndex,
  output logic                outValid
);

  // The counter holds either the start latency or the window length, so it is
  // as wide as the larger of the two.
  localparam int CNT_W = (DELAY_W > STRIDE_W) ? DELAY_W : STRIDE_W;

  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
  localparam logic [STRIDE_W-1:0] IDX_ZERO = {STRIDE_W{1'b0}};
  localparam logic [STRIDE_W-1:0] IDX_ONE  = STRIDE_W'(1'b1);
  localparam logic [DATA_W-1:0]   DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]   SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]   SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_MAX    = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_SUM    = 2'd2,
    MODE_ARGMAX = 2'd3
  } mode_e;

  // Two's complement add clamped to the signed DATA_W range.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    logic              ovf;
    s   = a + b;
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    return ovf ? (a[DATA_W-1] ? SAT_MIN : SAT_MAX) : s;
  endfunction

  logic [CNT_W-1:0]    delay_q, delay_d;
  mode_e               mode_q, mode_d;
  logic                armed_q, armed_d;
  logic [DATA_W-1:0]   stored_q, stored_d;
  logic [STRIDE_W-1:0] idx_q, idx_d;
  logic [STRIDE_W-1:0] out_index_q, out_index_d;
  logic                out_valid_q, out_valid_d;

  logic start_s;
  logic last_s;
  logic acc_en_s;
  logic in_gt_s;
  logic in_lt_s;

  // Window framing: start/last strobes and accumulate enable.
  always_comb begin
    start_s  = (delay_q == CNT_ZERO) && !run;
    last_s   = running && (armed_q || start_s) &&
               (((delay_q == CNT_ONE) && !run) ||
                (start_s && (strideMinusOne == IDX_ZERO)));
    // Nothing accumulates on a run cycle or before the first start, so an
    // aborted or not-yet-started window leaves the last result visible.
    acc_en_s = running && !run && (start_s || armed_q);
    in_gt_s  = $signed(in0) > $signed(stored_q);
    in_lt_s  = $signed(in0) < $signed(stored_q);
  end

  // Delay counter, configuration latch and arming.
  always_comb begin
    delay_d = delay_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    if (run) begin
      delay_d = CNT_W'(delay0);
      mode_d  = mode_e'(mode);
      armed_d = 1'b0;
    end else if (delay_q != CNT_ZERO) begin
      delay_d = delay_q - CNT_ONE;
    end else begin
      delay_d = CNT_W'(strideMinusOne);
    end
    if (!run && start_s && running) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_d;
    end
  end

  // Reduction datapath; strict compares keep the earliest of tied elements.
  always_comb begin
    stored_d    = stored_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_valid_d = last_s;
    if (acc_en_s) begin
      if (start_s) begin
        stored_d    = in0;
        idx_d       = IDX_ZERO;
        out_index_d = IDX_ZERO;
      end else begin
        idx_d = idx_q + IDX_ONE;
        case (mode_q)
          MODE_MAX, MODE_ARGMAX: begin
            if (in_gt_s) begin
              stored_d    = in0;
              out_index_d = idx_q + IDX_ONE;
            end else begin
              stored_d = stored_q;
            end
          end
          MODE_MIN: begin
            if (in_lt_s) begin
              stored_d    = in0;
              out_index_d = idx_q + IDX_ONE;
            end else begin
              stored_d = stored_q;
            end
          end
          MODE_SUM: begin
            stored_d    = (SAT != 0) ? sat_add(stored_q, in0) : (stored_q + in0);
            out_index_d = idx_q + IDX_ONE;
          end
          default: begin
            stored_d = stored_q;
          end
        endcase
      end
    end else begin
      stored_d = stored_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q     <= CNT_ZERO;
      mode_q      <= MODE_MAX;
      armed_q     <= 1'b0;
      stored_q    <= DATA_ZERO;
      idx_q       <= IDX_ZERO;
      out_index_q <= IDX_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      delay_q     <= delay_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
      stored_q    <= stored_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out0     = stored_q;
  assign outIndex = out_index_q;
  assign outValid = out_valid_q;

endmodule
